// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control-bus bit positions and load-size encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: CTRL_* bit indices into the per-instruction control bus, size_e load-size codes.
package mips_pipe_pkg;

  // Control-bus bit positions; bits above CTRL_UNS are carried but not interpreted here.
  localparam int CTRL_REGW  = 0;  // register-file write
  localparam int CTRL_M2R   = 1;  // writeback takes load data instead of ALU result
  localparam int CTRL_SZ_LO = 2;  // two-bit load size at [CTRL_SZ_LO +: 2]
  localparam int CTRL_UNS   = 4;  // zero-extend (1) / sign-extend (0) sub-word loads

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } size_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction: selects a byte/half/word lane of a memory word and extends it.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; shared with the MEM-stage forwarding path.
// Ports: data (raw memory word), off (byte offset), size (size_e code), uns (zero-extend), value (result).
module load_align
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFFW  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFFW-1:0]   off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Lanes are naturally aligned: low offset bits below the lane size are ignored.
  assign byte_v = 8'(data >> {off, 3'b000});
  assign half_v = 16'(data >> {off[OFFW-1:1], 4'b0000});

  generate
    if (DATA_W == 32) begin : g_word32
      assign word_v = data[31:0];
    end else begin : g_wordn
      assign word_v = 32'(data >> {off[OFFW-1:2], 5'b00000});
    end
  endgenerate

  always_comb begin
    value = data;
    case (size)
      SZ_BYTE: value = {{(DATA_W-8){byte_v[7] & ~uns}}, byte_v};
      SZ_HALF: value = {{(DATA_W-16){half_v[15] & ~uns}}, half_v};
      SZ_WORD: value = DATA_W'({{(DATA_W-32){word_v[31] & ~uns}}, word_v});
      default: value = data;  // SZ_FULL: whole word, no extension
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file write-port generation.
// Latency: 1 cycle from in_* to out_*/wb_*; no combinational in->out path.
// Backpressure: stall_i holds all state; flush_i (wins over stall_i) loads a bubble.
// Ports: clk/reset (async, active-high); stall_i, flush_i; in_valid/ctrl/mem_data/alu_result/wreg;
//        out_* registered copies; wb_we/wb_addr/wb_data register-file write port.
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_wreg,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_AW-1:0] out_wreg,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int OFFW = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] wreg;
  } stage_t;

  stage_t st_d, st_q;
  logic [DATA_W-1:0] load_value;

  assign st_d = '{valid: in_valid, ctrl: in_ctrl, mem_data: in_mem_data,
                  alu_result: in_alu_result, wreg: in_wreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         st_q <= '0;
    else if (flush_i)  st_q <= '0;
    else if (!stall_i) st_q <= st_d;
  end

  assign out_valid      = st_q.valid;
  assign out_ctrl       = st_q.ctrl;
  assign out_mem_data   = st_q.mem_data;
  assign out_alu_result = st_q.alu_result;
  assign out_wreg       = st_q.wreg;

  // The load's effective address is the ALU result, so its low bits give the byte lane.
  load_align #(.DATA_W(DATA_W)) u_load_align (
    .data  (st_q.mem_data),
    .off   (st_q.alu_result[OFFW-1:0]),
    .size  (st_q.ctrl[CTRL_SZ_LO +: 2]),
    .uns   (st_q.ctrl[CTRL_UNS]),
    .value (load_value)
  );

  // r0 is hard-wired zero, so a write to it is suppressed here rather than in the register file.
  assign wb_we   = st_q.valid & st_q.ctrl[CTRL_REGW] & (st_q.wreg != '0);
  assign wb_addr = st_q.wreg;
  assign wb_data = st_q.ctrl[CTRL_M2R] ? load_value : st_q.alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed checks of mem_wb_stage at DATA_W=32 and DATA_W=64 against a reference model.
// Latency: model expects results 1 cycle after inputs are presented.
// Backpressure: stall/flush behaviour modelled with plain register semantics.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, in_valid;
  logic [4:0]  in_ctrl, in_wreg;
  logic [63:0] in_mem, in_alu;

  logic        v32, we32, v64, we64;
  logic [4:0]  c32, w32, a32, c64, w64, a64;
  logic [31:0] m32, r32, d32;
  logic [63:0] m64, r64, d64;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit        valid;
    bit [4:0]  ctrl;
    bit [63:0] mem;
    bit [63:0] alu;
    bit [4:0]  wreg;
  } mstate_t;

  mstate_t ms32, ms64;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(5)) dut32 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_mem_data(in_mem[31:0]),
    .in_alu_result(in_alu[31:0]), .in_wreg(in_wreg),
    .out_valid(v32), .out_ctrl(c32), .out_mem_data(m32), .out_alu_result(r32),
    .out_wreg(w32), .wb_we(we32), .wb_addr(a32), .wb_data(d32)
  );

  mem_wb_stage #(.DATA_W(64), .REG_AW(5), .CTRL_W(5)) dut64 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_mem_data(in_mem),
    .in_alu_result(in_alu), .in_wreg(in_wreg),
    .out_valid(v64), .out_ctrl(c64), .out_mem_data(m64), .out_alu_result(r64),
    .out_wreg(w64), .wb_we(we64), .wb_addr(a64), .wb_data(d64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load value from first principles: byte offset within the word, aligned lane, then extension.
  function automatic bit [63:0] ref_load(bit [63:0] mem, bit [63:0] alu, bit [4:0] ctrl, int dw);
    longint unsigned nbytes, off, pos, w, raw;
    nbytes = dw / 8;
    off    = alu % nbytes;
    case (ctrl[3:2])
      2'd0: begin w = 8;  pos = off;           end
      2'd1: begin w = 16; pos = (off / 2) * 2; end
      2'd2: begin w = 32; pos = (off / 4) * 4; end
      default: return mem;
    endcase
    raw = (mem >> (8 * pos)) & ((64'd1 << w) - 1);
    if (!ctrl[4] && raw >= (64'd1 << (w - 1))) raw = raw - (64'd1 << w);
    if (dw == 32) raw = raw & 64'hFFFF_FFFF;
    return raw;
  endfunction

  task automatic compare_one(input string p, input int dw, input mstate_t s,
                             input logic v, input logic [4:0] c, input logic [63:0] m,
                             input logic [63:0] r, input logic [4:0] w, input logic we,
                             input logic [4:0] a, input logic [63:0] d);
    bit exp_we;
    exp_we = s.valid && s.ctrl[0] && (s.wreg != 0);
    check({p, ".valid"}, 64'(v), 64'(s.valid));
    check({p, ".ctrl"},  64'(c), 64'(s.ctrl));
    check({p, ".mem"},   m, s.mem);
    check({p, ".alu"},   r, s.alu);
    check({p, ".wreg"},  64'(w), 64'(s.wreg));
    check({p, ".wb_we"}, 64'(we), 64'(exp_we));
    check({p, ".wb_addr"}, 64'(a), 64'(s.wreg));
    check({p, ".wb_data"}, d, s.ctrl[1] ? ref_load(s.mem, s.alu, s.ctrl, dw) : s.alu);
  endtask

  task automatic compare_all();
    compare_one("d32", 32, ms32, v32, c32, {32'd0, m32}, {32'd0, r32}, w32, we32, a32, {32'd0, d32});
    compare_one("d64", 64, ms64, v64, c64, m64, r64, w64, we64, a64, d64);
  endtask

  task automatic model_clear();
    ms32 = '{default: '0};
    ms64 = '{default: '0};
  endtask

  // One clock: drive at negedge, update the model on the rising edge, compare just after it.
  task automatic apply(input bit st, input bit fl, input bit v, input bit [4:0] c,
                       input bit [63:0] m, input bit [63:0] a, input bit [4:0] w);
    @(negedge clk);
    stall_i = st; flush_i = fl; in_valid = v; in_ctrl = c; in_mem = m; in_alu = a; in_wreg = w;
    @(posedge clk);
    #1;
    if (fl) model_clear();
    else if (!st) begin
      ms32 = '{valid: v, ctrl: c, mem: m & 64'hFFFF_FFFF, alu: a & 64'hFFFF_FFFF, wreg: w};
      ms64 = '{valid: v, ctrl: c, mem: m, alu: a, wreg: w};
    end
    compare_all();
  endtask

  initial begin
    reset = 1'b1; stall_i = 0; flush_i = 0; in_valid = 0;
    in_ctrl = '0; in_mem = '0; in_alu = '0; in_wreg = '0;
    model_clear();
    #12;
    compare_all();                       // reset state
    @(negedge clk);
    reset = 1'b0;

    // lb with sign extension
    apply(0, 0, 1, 5'b00011, 64'h1234_80FF, 64'h1001, 5'd8);
    check("lb.we", 64'(we32), 64'd1);
    check("lb.addr", 64'(a32), 64'd8);
    check("lb.data", 64'(d32), 64'hFFFF_FF80);

    // lhu then lh at the upper half
    apply(0, 0, 1, 5'b10111, 64'h1234_80FF, 64'h1002, 5'd9);
    check("lhu.data", 64'(d32), 64'h0000_1234);
    apply(0, 0, 1, 5'b00111, 64'h1234_80FF, 64'h1002, 5'd9);
    check("lh.data", 64'(d32), 64'h0000_1234);

    // ALU write to r0 suppressed, to r3 issued
    apply(0, 0, 1, 5'b00001, 64'h0, 64'hDEAD_BEEF, 5'd0);
    check("r0.we", 64'(we32), 64'd0);
    apply(0, 0, 1, 5'b00001, 64'h0, 64'hDEAD_BEEF, 5'd3);
    check("r3.we", 64'(we32), 64'd1);
    check("r3.data", 64'(d32), 64'hDEAD_BEEF);

    // Stall three cycles while inputs change, then release
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 5'b00001, 64'(i), 64'(32'h100 + i), 5'(i + 4));
      check("stall.data", 64'(d32), 64'hDEAD_BEEF);
    end
    apply(0, 0, 1, 5'b00001, 64'h0, 64'h5555, 5'd7);
    check("release.data", 64'(d32), 64'h5555);

    // Flush wins over stall
    apply(1, 1, 1, 5'b00011, 64'h1234_80FF, 64'h1001, 5'd8);
    check("flush.valid", 64'(v32), 64'd0);
    check("flush.ctrl", 64'(c32), 64'd0);
    check("flush.we", 64'(we32), 64'd0);

    // 64-bit lw unsigned at offset 4
    apply(0, 0, 1, 5'b11011, 64'h89AB_CDEF_0123_4567, 64'h4, 5'd5);
    check("lwu64.data", d64, 64'h0000_0000_89AB_CDEF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit [4:0] rw;
      rw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      apply($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
            5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rw);
    end

    // Asynchronous reset mid-cycle with a live instruction held
    apply(0, 0, 1, 5'b00011, 64'h1234_80FF, 64'h1001, 5'd8);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    check("areset.we32", 64'(we32), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
